// File: rtl/decode_stage.sv
// decode_stage: single-register instruction decode stage with a load-use
// scoreboard and sticky halt. Optional feature macro: DECODE_ILLEGAL_TRAP_EN
// (when defined, opcodes 2 and 9..15 trap as illegal; otherwise they are NOPs).
module decode_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [2:0]        out_rd,
    output logic [2:0]        out_rs1,
    output logic [2:0]        out_rs2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              out_alu_src,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_halt,
    output logic              out_illegal,
    output logic [3:0]        out_alu_op,
    input  logic              flush,
    output logic              halted
);

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_LI    = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;

    localparam int unsigned SB_N = 8;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       halt;
        logic       illegal;
        logic [3:0] alu_op;
    } ctrl_t;

    ctrl_t             ctrl_d, ctrl_q;
    logic [DATA_W-1:0] imm_d, imm_q;
    logic [PC_W-1:0]   pc_q;
    logic [2:0]        rd_q, rs1_q, rs2_q;
    logic              valid_q, halted_q;
    logic [2:0]        sb_q [SB_N];
    logic [2:0]        sb_d [SB_N];

    logic [3:0] opcode;
    logic       src_a_en, src_b_en;
    logic [2:0] src_a, src_b;
    logic       busy_a, busy_b, hazard;
    logic       accept, fire, stop_held;

    assign opcode = in_instr[31:28];

    // Decode controls, immediate and source-register usage of the incoming instruction
    always_comb begin
        ctrl_d   = '0;
        imm_d    = '0;
        src_a_en = 1'b0;
        src_b_en = 1'b0;
        src_a    = in_instr[24:22];
        src_b    = in_instr[21:19];
        case (opcode)
            OP_HALT: ctrl_d.halt = 1'b1;
            OP_ADD, OP_MUL: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = (opcode == OP_MUL) ? 4'd1 : 4'd0;
                src_a_en         = 1'b1;
                src_b_en         = 1'b1;
            end
            OP_LI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = 4'd2;
                imm_d            = {{(DATA_W-25){in_instr[24]}}, in_instr[24:0]};
            end
            OP_LOAD: begin
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.alu_op     = 4'd3;
                imm_d             = {{(DATA_W-16){in_instr[21]}}, in_instr[21:6]};
                src_a_en          = 1'b1;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = 4'd3;
                imm_d            = {{(DATA_W-16){in_instr[21]}}, in_instr[21:6]};
                src_a            = in_instr[27:25];
                src_b            = in_instr[24:22];
                src_a_en         = 1'b1;
                src_b_en         = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                imm_d         = {{(DATA_W-22){in_instr[21]}}, in_instr[21:0]};
                src_a_en      = 1'b1;
                src_b_en      = 1'b1;
            end
            OP_JMP: begin
                ctrl_d.jump = 1'b1;
                imm_d       = {{(DATA_W-28){in_instr[27]}}, in_instr[27:0]};
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                ctrl_d.illegal = 1'b1;
`else
                ctrl_d.illegal = 1'b0;
`endif
            end
        endcase
    end

    // Load-use hazard: held LOAD targets a source, or a source is still cooling down
    assign busy_a = src_a_en && ((valid_q && ctrl_q.mem_read && (rd_q == src_a)) ||
                                 (sb_q[src_a] != 3'd0));
    assign busy_b = src_b_en && ((valid_q && ctrl_q.mem_read && (rd_q == src_b)) ||
                                 (sb_q[src_b] != 3'd0));
    assign hazard = busy_a || busy_b;

    assign stop_held = valid_q && (ctrl_q.halt || ctrl_q.illegal);
    assign in_ready  = !rst && !halted_q && !flush && !hazard && !stop_held &&
                       (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign fire      = valid_q && out_ready;

    // Scoreboard next state: firing LOAD reloads its rd, all other busy entries count down
    always_comb begin
        for (int i = 0; i < int'(SB_N); i++) begin
            sb_d[i] = sb_q[i];
            if (fire && ctrl_q.mem_read && (rd_q == 3'(i))) begin
                sb_d[i] = 3'(LOAD_LAT);
            end else if (sb_q[i] != 3'd0) begin
                sb_d[i] = sb_q[i] - 3'd1;
            end
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SB_N); i++) sb_q[i] <= 3'd0;
        end else begin
            for (int i = 0; i < int'(SB_N); i++) sb_q[i] <= sb_d[i];
        end
    end

    // Output register and sticky halt status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            ctrl_q   <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            rd_q     <= 3'd0;
            rs1_q    <= 3'd0;
            rs2_q    <= 3'd0;
        end else begin
            if (fire && (ctrl_q.halt || ctrl_q.illegal)) halted_q <= 1'b1;
            if (accept) begin
                valid_q <= 1'b1;
                ctrl_q  <= ctrl_d;
                imm_q   <= imm_d;
                pc_q    <= in_pc;
                rd_q    <= in_instr[27:25];
                rs1_q   <= in_instr[24:22];
                rs2_q   <= in_instr[21:19];
            end else if (fire || flush) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = valid_q;
    assign halted         = halted_q;
    assign out_pc         = pc_q;
    assign out_rd         = rd_q;
    assign out_rs1        = rs1_q;
    assign out_rs2        = rs2_q;
    assign out_imm        = imm_q;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_alu_src    = ctrl_q.alu_src;
    assign out_branch     = ctrl_q.branch;
    assign out_jump       = ctrl_q.jump;
    assign out_halt       = ctrl_q.halt;
    assign out_illegal    = ctrl_q.illegal;
    assign out_alu_op     = ctrl_q.alu_op;

endmodule
